if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS 5-stage pipeline, directly upstream of ID.
- Owns the PC and drives a req/ack instruction-memory port that may take several cycles to answer.
- Applies the pipeline controller's pc_src redirect, if_en stall and if_rst flush.
- Presents one instruction per cycle, with its PC and valid flag, to the IF/ID boundary.

---
 rtl/if_fetch_stage.sv | 177 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding req/ack
// instruction-memory port and hands one instruction per cycle to IF/ID.
//
// state | meaning
// IDLE  | after reset/flush, no request; fetch starts next cycle
// REQ   | request to pc in flight; ack data is delivered or buffered
// KILL  | stale request in flight; its ack data is dropped
// FULL  | stalled with one fetched instruction held in the buffer
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_en,
  input  logic              if_rst,
  input  logic [2:0]        pc_src,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              br_eq,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              if_valid,
  output logic              redirect_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_KILL, S_FULL} state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
  logic [31:0]       buf_inst_q, buf_inst_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic              redirect_q, redirect_d;

  logic              taken;
  logic              take;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;
  logic              outstanding;

  always_comb begin
    taken      = 1'b0;
    target_raw = br_target;
    case (pc_src)
      3'd1: begin
        taken      = 1'b1;
        target_raw = jump_target;
      end
      3'd2: begin
        taken      = 1'b1;
        target_raw = jr_target;
      end
      3'd3:    taken = br_eq;
      3'd4:    taken = ~br_eq;
      default: taken = 1'b0;
    endcase
  end

  assign target = {target_raw[ADDR_W-1:2], 2'b00};
  // Redirects are ignored in IDLE: the pipeline behind us was just flushed.
  assign take   = if_en & ~if_rst & taken & (state_q != S_IDLE);

  assign imem_req     = (state_q == S_REQ) || (state_q == S_KILL);
  assign imem_addr    = (state_q == S_KILL) ? kill_addr_q : pc_q;
  assign outstanding  = imem_req & ~imem_ack;
  assign inst_out     = inst_q;
  assign pc_out       = pc_out_q;
  assign if_valid     = valid_q;
  assign redirect_out = redirect_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    valid_d     = if_en ? 1'b0 : valid_q;
    redirect_d  = 1'b0;

    if (if_rst) begin
      pc_d    = RESET_PC_AL;
      valid_d = 1'b0;
      if (outstanding) begin
        kill_addr_d = imem_addr;
        state_d     = S_KILL;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            if (take) begin
              pc_d       = target;
              redirect_d = 1'b1;
            end else begin
              pc_d = pc_q + ADDR_W'(4);
              if (if_en) begin
                inst_d   = imem_rdata;
                pc_out_d = pc_q;
                valid_d  = 1'b1;
              end else begin
                buf_inst_d = imem_rdata;
                buf_pc_d   = pc_q;
                state_d    = S_FULL;
              end
            end
          end else if (take) begin
            pc_d        = target;
            redirect_d  = 1'b1;
            kill_addr_d = pc_q;
            state_d     = S_KILL;
          end
        end
        S_KILL: begin
          if (take) begin
            pc_d       = target;
            redirect_d = 1'b1;
          end
          if (imem_ack) state_d = S_REQ;
        end
        S_FULL: begin
          if (take) begin
            pc_d       = target;
            redirect_d = 1'b1;
            state_d    = S_REQ;
          end else if (if_en) begin
            inst_d   = buf_inst_q;
            pc_out_d = buf_pc_q;
            valid_d  = 1'b1;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC_AL;
      kill_addr_q <= '0;
      buf_inst_q  <= '0;
      buf_pc_q    <= '0;
      inst_q      <= '0;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
      redirect_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      redirect_q  <= redirect_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_en, if_rst, br_eq, imem_ack;
  logic [2:0]  pc_src;
  logic [31:0] jump_target, jr_target, br_target, imem_rdata;
  logic        imem_req, if_valid, redirect_out;
  logic [31:0] imem_addr, inst_out, pc_out;

  int n_vec = 0;
  int n_err = 0;
  bit dir_mode = 1'b1;

  if_fetch_stage #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .if_en(if_en), .if_rst(if_rst), .pc_src(pc_src),
    .jump_target(jump_target), .jr_target(jr_target), .br_target(br_target),
    .br_eq(br_eq), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out),
    .pc_out(pc_out), .if_valid(if_valid), .redirect_out(redirect_out)
  );

  always #5 clk = ~clk;

  // Model: pc, an optional in-flight stale fetch, and a queue of fetched
  // {inst, pc} pairs waiting for ID (never deeper than one).
  logic [31:0] m_pc, m_kaddr, m_inst, m_pcout;
  logic        m_idle, m_kill, m_valid, m_redir;
  logic [63:0] m_buf[$];

  function automatic logic exp_req();
    return !m_idle && (m_buf.size() == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_kill ? m_kaddr : m_pc;
  endfunction

  function automatic logic is_taken(logic [2:0] s, logic eq);
    return (s == 3'd1) || (s == 3'd2) || (s == 3'd3 && eq) || (s == 3'd4 && !eq);
  endfunction

  function automatic logic [31:0] target_of(logic [2:0] s);
    logic [31:0] t;
    t = (s == 3'd1) ? jump_target : (s == 3'd2) ? jr_target : br_target;
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_kaddr = '0; m_inst = '0; m_pcout = '0;
    m_idle = 1'b1; m_kill = 1'b0; m_valid = 1'b0; m_redir = 1'b0;
    m_buf.delete();
  endtask

  task automatic model_step();
    logic        req_now, take;
    logic [31:0] addr_now, tgt;
    logic [63:0] e;
    req_now  = exp_req();
    addr_now = exp_addr();
    take     = if_en && !if_rst && !m_idle && is_taken(pc_src, br_eq);
    tgt      = target_of(pc_src);
    m_redir  = 1'b0;
    if (if_en) m_valid = 1'b0;
    if (if_rst) begin
      m_valid = 1'b0;
      m_buf.delete();
      if (req_now && !imem_ack) begin
        m_kill = 1'b1; m_kaddr = addr_now; m_idle = 1'b0;
      end else begin
        m_kill = 1'b0; m_idle = 1'b1;
      end
      m_pc = RESET_PC;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_buf.size() != 0) begin
      if (take) begin
        m_buf.delete(); m_pc = tgt; m_redir = 1'b1;
      end else if (if_en) begin
        e = m_buf.pop_front();
        m_inst = e[63:32]; m_pcout = e[31:0]; m_valid = 1'b1;
      end
    end else begin
      if (imem_ack) begin
        if (!m_kill && !take) begin
          if (if_en) begin
            m_inst = imem_rdata; m_pcout = m_pc; m_valid = 1'b1;
          end else begin
            m_buf.push_back({imem_rdata, m_pc});
          end
          m_pc = m_pc + 32'd4;
        end
        m_kill = 1'b0;
      end else if (take && !m_kill) begin
        m_kill = 1'b1; m_kaddr = m_pc;
      end
      if (take) begin
        m_pc = tgt; m_redir = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
    check("imem_addr", imem_addr, exp_addr());
    check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    check("inst_out", inst_out, m_inst);
    check("pc_out", pc_out, m_pcout);
    check("redirect_out", {31'b0, redirect_out}, {31'b0, m_redir});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic en, input logic irst, input logic [2:0] src,
                        input logic eq, input logic ack);
    if_en = en; if_rst = irst; pc_src = src; br_eq = eq; imem_ack = ack;
    imem_rdata = dir_mode ? exp_addr() : $urandom;
  endtask

  initial begin
    rst = 1'b1; if_en = 1'b1; if_rst = 1'b0; pc_src = '0; br_eq = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    jump_target = '0; jr_target = '0; br_target = '0;
    #1 rst = 1'b0;
    #2;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_redir", {31'b0, redirect_out}, 32'd0);
    rst = 1'b1;

    // zero-wait memory returning word = addr
    set_in(1, 0, 0, 0, 1); cyc();
    check("zw_req", {31'b0, imem_req}, 32'd1);
    check("zw_addr0", imem_addr, 32'h0);
    set_in(1, 0, 0, 0, 1); cyc();
    check("zw_valid", {31'b0, if_valid}, 32'd1);
    check("zw_pc0", pc_out, 32'h0);
    check("zw_addr4", imem_addr, 32'h4);
    set_in(1, 0, 0, 0, 1); cyc();
    check("zw_pc4", pc_out, 32'h4);
    check("zw_inst4", inst_out, 32'h4);

    // 3-cycle ack latency
    for (int i = 0; i < 9; i++) begin
      set_in(1, 0, 0, 0, (i % 3) == 2); cyc();
      if (i == 0) begin
        check("lat_bubble", {31'b0, if_valid}, 32'd0);
        check("lat_addr_hold", imem_addr, 32'h8);
      end
      if (i == 2) check("lat_pc8", pc_out, 32'h8);
    end

    // taken BEQ while request to 0x14 is outstanding
    br_target = 32'h40;
    set_in(1, 0, 3, 1, 0); cyc();
    check("beq_redir", {31'b0, redirect_out}, 32'd1);
    check("beq_old_addr", imem_addr, 32'h14);
    set_in(1, 0, 0, 0, 0); cyc();
    check("beq_pulse_once", {31'b0, redirect_out}, 32'd0);
    set_in(1, 0, 0, 0, 1); cyc();
    check("beq_new_addr", imem_addr, 32'h40);
    check("beq_dropped", {31'b0, if_valid}, 32'd0);
    set_in(1, 0, 0, 0, 1); cyc();
    check("beq_first", pc_out, 32'h40);
    set_in(1, 0, 3, 0, 1); cyc();
    check("beq_nt_redir", {31'b0, redirect_out}, 32'd0);
    check("beq_nt_pc", pc_out, 32'h44);

    // stall with zero-wait memory
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 1); cyc();
    end
    check("stall_req", {31'b0, imem_req}, 32'd0);
    check("stall_pc_frozen", pc_out, 32'h44);
    check("stall_addr", imem_addr, 32'h4C);
    set_in(1, 0, 0, 0, 1); cyc();
    check("unstall_buf", pc_out, 32'h48);
    check("unstall_inst", inst_out, 32'h48);
    set_in(1, 0, 0, 0, 1); cyc();
    check("unstall_next", pc_out, 32'h4C);
    set_in(0, 0, 0, 0, 1); cyc();

    // JR out of FULL, then same-cycle ack + jump
    jr_target = 32'h1003;
    set_in(1, 0, 2, 0, 0); cyc();
    check("jr_addr", imem_addr, 32'h1000);
    check("jr_valid", {31'b0, if_valid}, 32'd0);
    jump_target = 32'h200;
    set_in(1, 0, 1, 0, 1); cyc();
    check("jmp_addr", imem_addr, 32'h200);
    check("jmp_redir", {31'b0, redirect_out}, 32'd1);
    jump_target = 32'hFFFF_FFFC;
    set_in(1, 0, 1, 0, 1); cyc();
    set_in(1, 0, 0, 0, 1); cyc();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc", pc_out, 32'hFFFF_FFFC);

    // if_rst mid-request
    jump_target = 32'h300;
    set_in(1, 0, 1, 0, 1); cyc();
    set_in(1, 0, 0, 0, 0); cyc();
    set_in(1, 1, 0, 0, 0); cyc();
    check("flush_valid", {31'b0, if_valid}, 32'd0);
    check("flush_old_addr", imem_addr, 32'h300);
    set_in(1, 0, 0, 0, 1); cyc();
    check("flush_new_addr", imem_addr, RESET_PC);
    set_in(1, 0, 0, 0, 1); cyc();
    check("flush_first", pc_out, RESET_PC);
    set_in(1, 0, 0, 0, 1); cyc();
    set_in(1, 0, 0, 0, 0); cyc();

    // async reset mid-request
    rst = 1'b0;
    #1;
    check("arst_pc_out", pc_out, 32'h0);
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_addr", imem_addr, RESET_PC);
    cyc(); cyc();
    rst = 1'b1;
    set_in(1, 0, 0, 0, 1); cyc();
    check("arst_restart", imem_addr, RESET_PC);
    check("arst_req_up", {31'b0, imem_req}, 32'd1);

    // randomized traffic
    dir_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      jump_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      jr_target   = $urandom;
      br_target   = $urandom;
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
             ($urandom_range(0, 9) < 5) ? 3'd0 : 3'($urandom_range(1, 7)),
             1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
      if (!rst) rst = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 300) == 0) rst = 1'b0;
      cyc();
    end
    rst = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
